// File: rtl/axi_rd_dma_bridge_pkg.sv
// ============================================================================
// Module      : axi_rd_dma_bridge_pkg
// Description : Shared request layout, AXI encodings and FSM states for the
//               read-DMA bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_rd_dma_bridge_pkg;

    localparam int LEN_BITS   = 28;
    localparam int BEAT_LOG   = 6;
    localparam int PAGE_LOG   = 12;
    localparam int BEATS_BITS = LEN_BITS - BEAT_LOG;
    localparam int REQ_BITS   = 96;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_64B   = 3'b110;
    localparam logic [3:0] AXI_CACHE_MOD  = 4'b0011;

    typedef struct packed {
        logic [3:0]          rsvd;
        logic [LEN_BITS-1:0] len;
        logic [63:0]         addr;
    } req_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/axi_rd_dma_bridge_burst_calc.sv
// ============================================================================
// Module      : axi_burst_calc
// Description : Beats for the next AR burst: min(remaining, MAX_BURST, beats
//               left before the next 4KB page boundary).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_burst_calc
    import axi_rd_dma_bridge_pkg::*;
#(
    parameter int REM_BITS  = BEATS_BITS,
    parameter int MAX_BURST = 64
) (
    input  logic [PAGE_LOG-1:0] cur_addr,
    input  logic [REM_BITS-1:0] rem,
    output logic [6:0]          burst
);

    logic [6:0] w_page_beats;
    logic [6:0] w_limit;

    always_comb begin
        // cur_addr is beat aligned, so the page remainder is a whole beat count
        w_page_beats = 7'd64 - {1'b0, cur_addr[PAGE_LOG-1:BEAT_LOG]};
        w_limit      = (w_page_beats < 7'(MAX_BURST)) ? w_page_beats : 7'(MAX_BURST);
        burst        = (rem < REM_BITS'(w_limit)) ? rem[6:0] : w_limit;
    end

endmodule

`default_nettype wire

// File: rtl/axi_rd_dma_bridge.sv
// ============================================================================
// Module      : axi_rd_dma_bridge
// Description : One-request-at-a-time read DMA: splits a request into 4KB-safe
//               AXI4 INCR bursts and streams the returned data out on AXI4S.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_rd_dma_bridge
    import axi_rd_dma_bridge_pkg::*;
#(
    parameter int ADDR_BITS       = 64,
    parameter int DATA_BITS       = 512,
    parameter int MAX_BURST       = 64,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                   aclk,
    input  logic                   areset,
    // request meta
    input  logic                   s_req_valid,
    output logic                   s_req_ready,
    input  logic [REQ_BITS-1:0]    s_req_data,
    // AXI4 read address
    output logic                   m_axi_arvalid,
    input  logic                   m_axi_arready,
    output logic [ADDR_BITS-1:0]   m_axi_araddr,
    output logic [7:0]             m_axi_arlen,
    output logic [2:0]             m_axi_arsize,
    output logic [1:0]             m_axi_arburst,
    output logic [3:0]             m_axi_arcache,
    output logic [3:0]             m_axi_arid,
    output logic [2:0]             m_axi_arprot,
    output logic [3:0]             m_axi_arqos,
    output logic                   m_axi_arlock,
    // AXI4 read data
    input  logic                   m_axi_rvalid,
    output logic                   m_axi_rready,
    input  logic [DATA_BITS-1:0]   m_axi_rdata,
    input  logic [1:0]             m_axi_rresp,
    input  logic                   m_axi_rlast,
    // AXI4 write side, unused
    output logic                   m_axi_awvalid,
    output logic [ADDR_BITS-1:0]   m_axi_awaddr,
    output logic [7:0]             m_axi_awlen,
    output logic                   m_axi_wvalid,
    output logic [DATA_BITS-1:0]   m_axi_wdata,
    output logic                   m_axi_wlast,
    output logic                   m_axi_bready,
    // AXI4S out
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [DATA_BITS-1:0]   m_axis_tdata,
    output logic [DATA_BITS/8-1:0] m_axis_tkeep,
    output logic                   m_axis_tlast,
    // completion
    output logic                   done_valid,
    output logic                   done_err
);

    localparam int OUT_BITS = $clog2(MAX_OUTSTANDING + 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_BITS-1:0]  r_cur_addr;
    logic [BEATS_BITS-1:0] r_rem;
    logic [BEATS_BITS-1:0] r_rcv_total;
    logic [BEATS_BITS-1:0] r_rcv_cnt;
    logic [OUT_BITS-1:0]   r_outstanding;
    logic                  r_err;
    logic                  r_done_valid;
    logic                  r_done_err;

    req_t                  w_req;
    logic [6:0]            w_burst;
    logic                  w_req_hs;
    logic                  w_ar_hs;
    logic                  w_r_hs;
    logic                  w_rx_en;

    axi_burst_calc #(
        .REM_BITS  (BEATS_BITS),
        .MAX_BURST (MAX_BURST)
    ) u_burst_calc (
        .cur_addr (r_cur_addr[PAGE_LOG-1:0]),
        .rem      (r_rem),
        .burst    (w_burst)
    );

    assign w_req    = req_t'(s_req_data);
    assign w_rx_en  = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
    assign w_req_hs = s_req_valid && s_req_ready;
    assign w_ar_hs  = m_axi_arvalid && m_axi_arready;
    assign w_r_hs   = m_axi_rvalid && m_axi_rready;

    assign s_req_ready   = (r_state == ST_IDLE) && !areset;

    // AR fields come straight from registered state, so they hold while stalled
    assign m_axi_arvalid = (r_state == ST_ISSUE) && (r_outstanding < OUT_BITS'(MAX_OUTSTANDING));
    assign m_axi_araddr  = r_cur_addr;
    assign m_axi_arlen   = 8'(w_burst - 7'd1);
    assign m_axi_arsize  = AXI_SIZE_64B;
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arcache = AXI_CACHE_MOD;
    assign m_axi_arid    = '0;
    assign m_axi_arprot  = '0;
    assign m_axi_arqos   = '0;
    assign m_axi_arlock  = 1'b0;

    assign m_axi_awvalid = 1'b0;
    assign m_axi_awaddr  = '0;
    assign m_axi_awlen   = '0;
    assign m_axi_wvalid  = 1'b0;
    assign m_axi_wdata   = '0;
    assign m_axi_wlast   = 1'b0;
    assign m_axi_bready  = 1'b0;

    // tlast marks the request's final beat, not each burst's rlast
    assign m_axis_tvalid = m_axi_rvalid && w_rx_en;
    assign m_axi_rready  = m_axis_tready && w_rx_en;
    assign m_axis_tdata  = m_axi_rdata;
    assign m_axis_tkeep  = '1;
    assign m_axis_tlast  = (r_rcv_cnt == r_rcv_total - 1'b1);

    assign done_valid    = r_done_valid;
    assign done_err      = r_done_err;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req_hs) begin
                    w_state_nxt = (w_req.len[LEN_BITS-1:BEAT_LOG] == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_ar_hs && (r_rem == BEATS_BITS'(w_burst))) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_rcv_cnt == r_rcv_total) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state       <= ST_IDLE;
            r_cur_addr    <= '0;
            r_rem         <= '0;
            r_rcv_total   <= '0;
            r_rcv_cnt     <= '0;
            r_outstanding <= '0;
            r_err         <= 1'b0;
            r_done_valid  <= 1'b0;
            r_done_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_done_valid <= (r_state == ST_DONE);
            r_done_err   <= (r_state == ST_DONE) && r_err;

            if (w_req_hs) begin
                r_cur_addr  <= ADDR_BITS'({w_req.addr[63:BEAT_LOG], BEAT_LOG'(0)});
                r_rem       <= w_req.len[LEN_BITS-1:BEAT_LOG];
                r_rcv_total <= w_req.len[LEN_BITS-1:BEAT_LOG];
            end else if (w_ar_hs) begin
                r_cur_addr  <= r_cur_addr + ADDR_BITS'({w_burst, BEAT_LOG'(0)});
                r_rem       <= r_rem - BEATS_BITS'(w_burst);
            end

            if (w_req_hs) begin
                r_rcv_cnt <= '0;
                r_err     <= 1'b0;
            end else if (w_r_hs) begin
                r_rcv_cnt <= r_rcv_cnt + 1'b1;
                if (m_axi_rresp != 2'b00) begin
                    r_err <= 1'b1;
                end
            end

            case ({w_ar_hs, w_r_hs && m_axi_rlast})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   if (r_outstanding != '0) r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axi_rd_dma_bridge.sv
// ============================================================================
// Module      : tb_axi_rd_dma_bridge
// Description : Scoreboard bench for axi_rd_dma_bridge with an AXI memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axi_rd_dma_bridge;

    logic         aclk = 1'b0;
    logic         areset = 1'b1;
    logic         s_req_valid, s_req_ready;
    logic [95:0]  s_req_data;
    logic         m_axi_arvalid, m_axi_arready;
    logic [63:0]  m_axi_araddr;
    logic [7:0]   m_axi_arlen;
    logic [2:0]   m_axi_arsize, m_axi_arprot;
    logic [1:0]   m_axi_arburst;
    logic [3:0]   m_axi_arcache, m_axi_arid, m_axi_arqos;
    logic         m_axi_arlock;
    logic         m_axi_rvalid, m_axi_rready, m_axi_rlast;
    logic [511:0] m_axi_rdata;
    logic [1:0]   m_axi_rresp;
    logic         m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready;
    logic [63:0]  m_axi_awaddr;
    logic [7:0]   m_axi_awlen;
    logic [511:0] m_axi_wdata;
    logic         m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [511:0] m_axis_tdata;
    logic [63:0]  m_axis_tkeep;
    logic         done_valid, done_err;

    always #5 aclk = ~aclk;

    axi_rd_dma_bridge #(.ADDR_BITS(64), .DATA_BITS(512), .MAX_BURST(64), .MAX_OUTSTANDING(8)) dut (
        .aclk(aclk), .areset(areset),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_data(s_req_data),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
        .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arcache(m_axi_arcache), .m_axi_arid(m_axi_arid), .m_axi_arprot(m_axi_arprot),
        .m_axi_arqos(m_axi_arqos), .m_axi_arlock(m_axi_arlock),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wdata(m_axi_wdata), .m_axi_wlast(m_axi_wlast),
        .m_axi_bready(m_axi_bready),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
        .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .done_valid(done_valid), .done_err(done_err)
    );

    typedef struct { logic [63:0] addr; logic [7:0] len; } ar_t;
    typedef struct { logic [511:0] data; logic last; } beat_t;

    ar_t         exp_ar[$];
    beat_t       exp_beat[$];
    logic        exp_err[$];
    logic [63:0] mb_addr[$];
    int          mb_len[$];

    int checks = 0, errors = 0, cyc = 0;
    int mb_beat = 0, out_model = 0, ar_cnt = 0, beat_cnt = 0, done_cnt = 0;
    int rbeat_total = 0, err_at = -1, done_cyc = 0, hs_cyc = 0, done_base = 0;
    int ar_gap = 0, r_gap = 0, trdy_mode = 0;
    bit hold = 1'b0, r_stuck = 1'b0, ar_pend = 1'b0;
    logic [71:0] ar_prev = '0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] pat(input logic [63:0] a);
        logic [511:0] d;
        for (int i = 0; i < 8; i++) d[i*64 +: 64] = a ^ (64'(i) << 56) ^ 64'h0123_4567_0000_0000;
        return d;
    endfunction

    // memory model + scoreboard: drive at negedge, sample what the next posedge will see
    initial begin
        ar_t   e;
        beat_t b;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
        m_axi_rresp = 2'b00; m_axi_rlast = 1'b0; m_axis_tready = 1'b1;
        forever begin
            @(negedge aclk);
            m_axi_arready = (ar_gap == 0) || ($urandom_range(0, 99) >= ar_gap);
            if (!r_stuck) begin
                if (!hold && mb_addr.size() > 0 && (r_gap == 0 || $urandom_range(0, 99) >= r_gap)) begin
                    m_axi_rvalid = 1'b1;
                    m_axi_rdata  = pat(mb_addr[0] + 64'(mb_beat) * 64);
                    m_axi_rlast  = (mb_beat == mb_len[0] - 1);
                    m_axi_rresp  = (rbeat_total == err_at) ? 2'b10 : 2'b00;
                end else begin
                    m_axi_rvalid = 1'b0;
                end
            end
            case (trdy_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = ~m_axis_tready;
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (m_axi_arvalid) begin
                if (ar_pend) chk("ar_stable", {m_axi_araddr, m_axi_arlen}, ar_prev);
                chk("ar_limit", out_model < 8, 1'b1);
            end
            ar_pend = m_axi_arvalid && !m_axi_arready;
            ar_prev = {m_axi_araddr, m_axi_arlen};
            if (m_axi_arvalid && m_axi_arready) begin
                chk("ar_expected", exp_ar.size() > 0, 1'b1);
                if (exp_ar.size() > 0) begin
                    e = exp_ar.pop_front();
                    chk("araddr", m_axi_araddr, e.addr);
                    chk("arlen", m_axi_arlen, e.len);
                end
                chk("ar_attr", {m_axi_arsize, m_axi_arburst, m_axi_arcache, m_axi_arid,
                                m_axi_arprot, m_axi_arqos, m_axi_arlock}, {3'b110, 2'b01, 4'b0011, 12'b0});
                mb_addr.push_back(m_axi_araddr);
                mb_len.push_back(int'(m_axi_arlen) + 1);
                out_model++;
                ar_cnt++;
            end
            if (m_axis_tvalid) begin
                chk("rready_mirror", m_axi_rready, m_axis_tready);
                if (m_axis_tready) begin
                    chk("beat_expected", exp_beat.size() > 0, 1'b1);
                    if (exp_beat.size() > 0) begin
                        b = exp_beat.pop_front();
                        chk("tdata", m_axis_tdata, b.data);
                        chk("tlast", m_axis_tlast, b.last);
                    end
                    chk("tkeep", m_axis_tkeep, {64{1'b1}});
                    beat_cnt++;
                end
            end
            r_stuck = m_axi_rvalid && !m_axi_rready;
            if (m_axi_rvalid && m_axi_rready && mb_addr.size() > 0) begin
                rbeat_total++;
                if (m_axi_rlast) begin
                    void'(mb_addr.pop_front());
                    void'(mb_len.pop_front());
                    mb_beat = 0;
                    out_model--;
                end else begin
                    mb_beat++;
                end
            end
            if (done_valid) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_expected", exp_err.size() > 0, 1'b1);
                if (exp_err.size() > 0) chk("done_err", done_err, exp_err.pop_front());
            end
        end
    end

    task automatic send_req(input logic [63:0] addr, input logic [31:0] len, input logic err);
        logic [63:0] a;
        int rem, bl, pg, total, k, n;
        a = {addr[63:6], 6'b0};
        total = int'(len[27:6]);
        rem = total;
        k = 0;
        while (rem > 0) begin
            pg = (4096 - int'(a[11:0])) / 64;
            bl = (rem < 64) ? rem : 64;
            if (bl > pg) bl = pg;
            exp_ar.push_back('{a, 8'(bl - 1)});
            for (int j = 0; j < bl; j++) begin
                exp_beat.push_back('{pat(a + 64'(j) * 64), (k == total - 1)});
                k++;
            end
            a = a + 64'(bl) * 64;
            rem = rem - bl;
        end
        exp_err.push_back(err);
        done_base = done_cnt;
        @(negedge aclk);
        s_req_valid = 1'b1;
        s_req_data  = {4'hA, len[27:0], addr};
        #1;
        n = 0;
        while (!s_req_ready && n < 200) begin
            @(negedge aclk);
            #1;
            n++;
        end
        chk("req_accept", s_req_ready, 1'b1);
        hs_cyc = cyc;
        @(posedge aclk);
        #1;
        s_req_valid = 1'b0;
    endtask

    task automatic wait_done(input int lim, input string tag);
        int n;
        n = 0;
        while (done_cnt == done_base && n < lim) begin
            @(negedge aclk);
            #2;
            n++;
        end
        chk(tag, done_cnt - done_base, 1);
        chk("sb_ar_empty", exp_ar.size(), 0);
        chk("sb_beat_empty", exp_beat.size(), 0);
    endtask

    initial begin
        int a0, b0, n;
        s_req_valid = 1'b0;
        s_req_data  = '0;
        repeat (3) @(negedge aclk);
        #1;
        chk("rst_ready", s_req_ready, 1'b0);
        chk("rst_arvalid", m_axi_arvalid, 1'b0);
        chk("rst_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_done", {done_valid, done_err}, 2'b00);
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        #1;
        chk("idle_ready", s_req_ready, 1'b1);
        chk("tieoff", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b000);

        a0 = ar_cnt;
        send_req(64'h1000, 256, 1'b0);
        wait_done(200, "t1_done");
        chk("t1_ar_cnt", ar_cnt - a0, 1);

        a0 = ar_cnt;
        send_req(64'h0FC0, 192, 1'b0);
        wait_done(200, "t2_done");
        chk("t2_ar_cnt", ar_cnt - a0, 2);

        a0 = ar_cnt; b0 = beat_cnt; hold = 1'b1;
        send_req(64'h0, 16384, 1'b0);
        repeat (200) @(negedge aclk);
        #2;
        chk("t3_ar_cnt", ar_cnt - a0, 4);
        chk("t3_no_beats", beat_cnt - b0, 0);
        hold = 1'b0;
        wait_done(1000, "t3_done");

        a0 = ar_cnt; hold = 1'b1;
        send_req(64'h20000, 65536, 1'b0);
        repeat (100) @(negedge aclk);
        #2;
        chk("t4_ar_cap", ar_cnt - a0, 8);
        chk("t4_arvalid_held", m_axi_arvalid, 1'b0);
        hold = 1'b0;
        wait_done(3000, "t4_done");
        chk("t4_ar_total", ar_cnt - a0, 16);

        trdy_mode = 1;
        err_at = rbeat_total + 1;
        send_req(64'h3000, 256, 1'b1);
        wait_done(200, "t5_done");
        err_at = -1;
        trdy_mode = 0;
        send_req(64'h3100, 256, 1'b0);
        wait_done(200, "t6_done");

        a0 = ar_cnt; b0 = beat_cnt;
        send_req(64'h4000, 0, 1'b0);
        wait_done(50, "t7_done");
        chk("t7_latency", done_cyc - hs_cyc, 2);
        chk("t7_no_ar", ar_cnt - a0, 0);
        chk("t7_no_beat", beat_cnt - b0, 0);

        send_req(64'hFFFF_FFFF_FFFF_FF80, 384, 1'b0);
        wait_done(200, "t8_wrap_done");
        send_req(64'h5010, 200, 1'b0);
        wait_done(200, "t9_trunc_done");

        ar_gap = 30; r_gap = 30; trdy_mode = 2;
        for (int i = 0; i < 6; i++) begin
            send_req(64'($urandom_range(0, 1023)) * 64, 32'($urandom_range(1, 80)) * 64, 1'b0);
            wait_done(3000, "rand_done");
        end
        ar_gap = 0; r_gap = 0; trdy_mode = 0;

        a0 = ar_cnt; hold = 1'b1;
        send_req(64'h7000, 256, 1'b0);
        n = 0;
        while (ar_cnt == a0 && n < 50) begin
            @(negedge aclk);
            n++;
        end
        repeat (2) @(negedge aclk);
        areset = 1'b1;
        exp_ar.delete(); exp_beat.delete(); exp_err.delete();
        mb_addr.delete(); mb_len.delete();
        mb_beat = 0; out_model = 0; hold = 1'b0;
        @(negedge aclk);
        #1;
        chk("rst2_ready", s_req_ready, 1'b0);
        chk("rst2_arvalid", m_axi_arvalid, 1'b0);
        chk("rst2_tvalid", m_axis_tvalid, 1'b0);
        chk("rst2_done", done_valid, 1'b0);
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        #1;
        chk("rst2_ready_after", s_req_ready, 1'b1);
        send_req(64'h8000, 128, 1'b0);
        wait_done(200, "post_rst_done");

        repeat (5) @(negedge aclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/axi_rd_dma_bridge.md
Name: axi_rd_dma_bridge

Overview:
Read-DMA stage that sits between a request-meta source and the card/host memory AXI4 port. It consumes one read request at a time from an LMetaIntf slave: 64-bit address plus byte length. It issues 4KB-safe AXI4 INCR read bursts and streams the returned data on an AXI4S master with tlast on the final beat. A one-cycle completion pulse with a sticky error flag is produced per request.

Parameters:
ADDR_BITS, 64, AXI4 address width
DATA_BITS, AXI_DATA_BITS (512), AXI4/AXI4S data width; beat = DATA_BITS/8 bytes (64)
LEN_BITS, 28, request byte-length field width
MAX_BURST, 64, max beats per AR burst (64 x 64B = 4KB)
MAX_OUTSTANDING, 8, max AR bursts issued but not yet fully returned

Ports:
aclk  in  1  clock
areset  in  1  synchronous, active-high reset
s_req  LMetaIntf.s  96  request: [63:0] addr, [91:64] len in bytes, [95:92] reserved (ignored)
m_axi  AXI4.m  iface  read master; AW/W/B channels tied off (tie_off_m semantics, bready=0)
m_axis  AXI4S.m  iface  read data out
done_valid  out  1  one-cycle pulse at request completion
done_err  out  1  valid with done_valid; 1 if any beat of the request had rresp != 2'b00

Behaviour:
- Reset: FSM=IDLE; s_req.ready=0 during reset; arvalid=0; m_axis.tvalid=0; done_valid=0; done_err=0; all counters 0.
- Reset mid-request abandons it. No recovery of in-flight AXI beats is required; the system resets the memory side together with this block.
- Request rules: addr and len are multiples of 64. Low 6 bits are ignored (truncated). total_beats = len>>6.
- FSM IDLE: s_req.ready=1. On valid&&ready, latch cur_addr=addr, rem=total_beats, rcv_total=total_beats, rcv_cnt=0, err=0.
  - total_beats==0: go to DONE directly. No AR is issued and no stream beat is produced.
  - Otherwise go to ISSUE.
- FSM ISSUE: s_req.ready=0.
  - burst = min(rem, MAX_BURST, (4096 - cur_addr[11:0])>>6).
  - arvalid=1 iff outstanding < MAX_OUTSTANDING.
  - AR fields: araddr=cur_addr, arlen=burst-1, arsize=3'b110, arburst=2'b01, arcache=4'b0011, arid=0, other AR fields 0.
  - araddr/arlen are registered and must stay stable while arvalid && !arready.
  - On arready: cur_addr+=burst*64, rem-=burst, outstanding++.
  - When rem reaches 0 after a handshake: go to DRAIN.
- FSM DRAIN: wait until rcv_cnt==rcv_total, then go to DONE.
- FSM DONE: done_valid=1 and done_err=err for exactly one cycle, then go to IDLE. Next request is accepted no earlier than the cycle after DONE.
- Outstanding counter: incremented on AR handshake, decremented on an R handshake with rlast. A simultaneous inc and dec leaves it unchanged. It never exceeds MAX_OUTSTANDING and never underflows.
- R to AXI4S pass-through, combinational, zero latency:
  - m_axis.tvalid=rvalid, m_axis.tdata=rdata, tkeep all ones, rready=m_axis.tready.
  - tlast=1 iff rcv_cnt==rcv_total-1. AXI rlast on intermediate bursts is NOT forwarded as tlast.
  - Each R handshake increments rcv_cnt. If rresp!=0, err is set and stays sticky until the next request is accepted.
- R beats arriving in IDLE (protocol violation) are not accepted: rready=0 in IDLE and DONE.
- Backpressure: tready low stalls R only. AR issue continues up to MAX_OUTSTANDING.
- Address arithmetic wraps modulo 2^ADDR_BITS. A burst never crosses a 4KB boundary.

Decomposition:
- lynxTypes additions:
  - typedef req_t packed struct {rsvd[3:0], len[LEN_BITS-1:0], addr[63:0]}
  - BEAT_LOG=6, PAGE_LOG=12
  - AXI_BURST_INCR=2'b01, AXI_SIZE_64B=3'b110
- One sub-module, axi_burst_calc (combinational): inputs cur_addr[11:0] and rem; output burst (7 bits). Kept separate for unit test.

Test Plan:
- addr=0x1000, len=256, tready=1 -> one AR: araddr=0x1000, arlen=3; 4 stream beats, tlast on beat 4 only; done_valid once, done_err=0.
- addr=0x0FC0, len=192 -> AR1 araddr=0x0FC0 arlen=0; AR2 araddr=0x1000 arlen=1; 3 beats, tlast only on the 3rd (not on AR1's rlast).
- addr=0, len=16384 with memory model holding arready=1 and rvalid=0 for 200 cycles -> exactly 4 ARs (arlen=63 each, 0x0/0x1000/0x2000/0x3000) with MAX_OUTSTANDING=8; then 256 beats, tlast on beat 256.
- MAX_OUTSTANDING=2, len=12288, rvalid delayed -> only 2 ARs issued before the first rlast; 3rd AR appears the cycle after the first rlast handshake.
- tready toggled 1-0-1-0 on a 4-beat request -> rready mirrors tready, data order preserved; beat 2 returns rresp=2'b10 -> done_err=1; next request with clean responses -> done_err=0.
- len=0 -> no arvalid, no tvalid, done_valid pulses 2 cycles after the s_req handshake. Separately, areset asserted during DRAIN -> next cycle arvalid=0, tvalid=0, done_valid=0, s_req.ready=0 while reset is held, s_req.ready=1 after release.
